// File: rtl/mips_id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// mips_id_ex_stage_pkg
// Shared types and helpers for the ID/EX pipeline register of the pipelined
// MIPS core.
//   ID_EX_DATA_W / ID_EX_REG_W : default datapath and register-number widths
//   id_ex_t                    : the registered ID/EX bundle
//   fwd_hit()                  : "does this writer target this source reg?"
// ALU_* and BR_* operation codes stay in the shared defines header.
// ---------------------------------------------------------------------------
package mips_id_ex_stage_pkg;

    localparam int ID_EX_DATA_W = 32;
    localparam int ID_EX_REG_W  = 5;

    // Everything ID hands to EX, held for one cycle (or longer on a freeze).
    typedef struct packed {
        logic                    valid;
        logic                    reg_we;
        logic                    mem_read;
        logic                    mem_write;
        logic [3:0]              alu_sel;
        logic [2:0]              brcond;
        logic                    use_imm;
        logic [ID_EX_REG_W-1:0]  rs_num;
        logic [ID_EX_REG_W-1:0]  rt_num;
        logic [ID_EX_REG_W-1:0]  rd_num;
        logic [ID_EX_DATA_W-1:0] rs_data;
        logic [ID_EX_DATA_W-1:0] rt_data;
        logic [ID_EX_DATA_W-1:0] imm;
    } id_ex_t;

    // A writer only ever supplies data for a nonzero register it really writes.
    function automatic logic fwd_hit(
        input logic                   valid,
        input logic                   we,
        input logic [ID_EX_REG_W-1:0] rd,
        input logic [ID_EX_REG_W-1:0] src
    );
        return valid & we & (rd != '0) & (rd == src);
    endfunction

endpackage

// File: rtl/mips_fwd_mux.sv
// ---------------------------------------------------------------------------
// mips_fwd_mux
// Single-operand forwarding selector at the ALU input.
//   i_ex_valid                : EX holds a real instruction (no forwarding otherwise)
//   i_src_num / i_stored      : source register number and the value captured in ID/EX
//   i_mem_* / i_wb_*          : writer state of the MEM and WB stages
//   o_value                   : operand value after forwarding
// MEM beats WB because it is the younger producer. Loads in MEM are never
// taken: their data is not ready, and the stall logic guarantees no consumer
// is in EX when one matches.
// ---------------------------------------------------------------------------
module mips_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              i_ex_valid,
    input  logic [REG_W-1:0]  i_src_num,
    input  logic [DATA_W-1:0] i_stored,
    input  logic              i_mem_valid,
    input  logic              i_mem_reg_we,
    input  logic              i_mem_is_load,
    input  logic [REG_W-1:0]  i_mem_rd_num,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic              i_wb_valid,
    input  logic              i_wb_reg_we,
    input  logic [REG_W-1:0]  i_wb_rd_num,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_value
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_ex_valid & i_mem_valid & i_mem_reg_we & ~i_mem_is_load &
                       (i_mem_rd_num != '0) & (i_mem_rd_num == i_src_num);
    assign w_wb_hit  = i_ex_valid & i_wb_valid & i_wb_reg_we &
                       (i_wb_rd_num != '0) & (i_wb_rd_num == i_src_num);

    assign o_value = w_mem_hit ? i_mem_result :
                     w_wb_hit  ? i_wb_data    : i_stored;

endmodule

// File: rtl/mips_id_ex_stage.sv
// ---------------------------------------------------------------------------
// mips_id_ex_stage
// ID/EX pipeline register feeding mips_ALU.
//   clk, rst                   : core clock, async active-high reset
//   id_*                       : decoded instruction from ID
//   mem_*, wb_*                : downstream writer state, used for forwarding
//   ext_stall                  : whole-pipeline freeze (HOLD)
//   flush                      : branch taken, squash the ID instruction
//   alu__op1/op2/sel, brcond   : ALU inputs (forwarded)
//   ex_*                       : registered control, rd and forwarded store data
//   id_stall                   : load-use hazard, ID must hold
// Update priority each edge: HOLD > BUBBLE > LOAD.
// ---------------------------------------------------------------------------
module mips_id_ex_stage
    import mips_id_ex_stage_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int REG_W  = ID_EX_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs_num,
    input  logic [REG_W-1:0]  id_rt_num,
    input  logic [REG_W-1:0]  id_rd_num,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [3:0]        id_alu_sel,
    input  logic [2:0]        id_brcond,
    input  logic              id_reg_we,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_valid,
    input  logic              mem_reg_we,
    input  logic              mem_is_load,
    input  logic [REG_W-1:0]  mem_rd_num,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_valid,
    input  logic              wb_reg_we,
    input  logic [REG_W-1:0]  wb_rd_num,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] alu__op1,
    output logic [DATA_W-1:0] alu__op2,
    output logic [3:0]        alu__sel,
    output logic [2:0]        brcond,
    output logic              ex_valid,
    output logic              ex_reg_we,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_W-1:0]  ex_rd_num,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              id_stall
);

    id_ex_t            r_ex;
    id_ex_t            w_load;
    id_ex_t            w_hold;
    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;
    logic              w_ld_hazard;

    // A load in EX cannot supply data until WB, so a dependent ID instruction
    // waits one cycle; the bubble then lets WB forwarding cover it.
    assign w_ld_hazard = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd_num != '0) &
                         ((id_uses_rs & (id_rs_num == r_ex.rd_num)) |
                          (id_uses_rt & (id_rt_num == r_ex.rd_num)));
    assign id_stall = w_ld_hazard;

    // Candidate register contents for LOAD and HOLD. The register file is not
    // write-through, so a same-cycle WB write is merged in here; during a
    // freeze the held operands keep tracking WB so they are not left stale.
    always_comb begin
        w_load           = '0;
        w_load.valid     = id_valid;
        w_load.reg_we    = id_reg_we;
        w_load.mem_read  = id_mem_read;
        w_load.mem_write = id_mem_write;
        w_load.alu_sel   = id_alu_sel;
        w_load.brcond    = id_brcond;
        w_load.use_imm   = id_use_imm;
        w_load.rs_num    = id_rs_num;
        w_load.rt_num    = id_rt_num;
        w_load.rd_num    = id_rd_num;
        w_load.imm       = id_imm;
        w_load.rs_data   = fwd_hit(wb_valid, wb_reg_we, wb_rd_num, id_rs_num) ? wb_data : id_rs_data;
        w_load.rt_data   = fwd_hit(wb_valid, wb_reg_we, wb_rd_num, id_rt_num) ? wb_data : id_rt_data;

        w_hold = r_ex;
        if (fwd_hit(wb_valid, wb_reg_we, wb_rd_num, r_ex.rs_num)) begin
            w_hold.rs_data = wb_data;
        end
        if (fwd_hit(wb_valid, wb_reg_we, wb_rd_num, r_ex.rt_num)) begin
            w_hold.rt_data = wb_data;
        end
    end

    // The ID/EX register. A flush during a freeze is simply not seen until the
    // freeze lifts, because its source keeps it asserted. Bubbles only clear
    // the control bits; stale data under ex_valid=0 is never consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
        end else if (ext_stall) begin
            r_ex <= w_hold;
        end else if (flush || w_ld_hazard) begin
            r_ex.valid     <= 1'b0;
            r_ex.reg_we    <= 1'b0;
            r_ex.mem_read  <= 1'b0;
            r_ex.mem_write <= 1'b0;
        end else begin
            r_ex <= w_load;
        end
    end

    mips_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .i_ex_valid    (r_ex.valid),
        .i_src_num     (r_ex.rs_num),
        .i_stored      (r_ex.rs_data),
        .i_mem_valid   (mem_valid),
        .i_mem_reg_we  (mem_reg_we),
        .i_mem_is_load (mem_is_load),
        .i_mem_rd_num  (mem_rd_num),
        .i_mem_result  (mem_result),
        .i_wb_valid    (wb_valid),
        .i_wb_reg_we   (wb_reg_we),
        .i_wb_rd_num   (wb_rd_num),
        .i_wb_data     (wb_data),
        .o_value       (w_rs_fwd)
    );

    mips_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .i_ex_valid    (r_ex.valid),
        .i_src_num     (r_ex.rt_num),
        .i_stored      (r_ex.rt_data),
        .i_mem_valid   (mem_valid),
        .i_mem_reg_we  (mem_reg_we),
        .i_mem_is_load (mem_is_load),
        .i_mem_rd_num  (mem_rd_num),
        .i_mem_result  (mem_result),
        .i_wb_valid    (wb_valid),
        .i_wb_reg_we   (wb_reg_we),
        .i_wb_rd_num   (wb_rd_num),
        .i_wb_data     (wb_data),
        .o_value       (w_rt_fwd)
    );

    // The immediate (including a shift amount in [10:6]) is a constant of
    // the instruction and never forwarded; stores always want the real rt.
    assign alu__op1      = w_rs_fwd;
    assign alu__op2      = r_ex.use_imm ? r_ex.imm : w_rt_fwd;
    assign ex_store_data = w_rt_fwd;
    assign alu__sel      = r_ex.alu_sel;
    assign brcond        = r_ex.brcond;
    assign ex_valid      = r_ex.valid;
    assign ex_reg_we     = r_ex.reg_we;
    assign ex_mem_read   = r_ex.mem_read;
    assign ex_mem_write  = r_ex.mem_write;
    assign ex_rd_num     = r_ex.rd_num;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_id_ex_stage
// Directed bench for the ID/EX register: reset, MEM/WB forwarding priority,
// load-use bubble, register 0, flush vs freeze, immediate operand and
// capture-side WB merge. Expected values are worked out by hand per step.
// ---------------------------------------------------------------------------
module tb_mips_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs_num, id_rt_num, id_rd_num;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_sel;
    logic [2:0]  id_brcond;
    logic        id_reg_we, id_mem_read, id_mem_write;
    logic        mem_valid, mem_reg_we, mem_is_load;
    logic [4:0]  mem_rd_num;
    logic [31:0] mem_result;
    logic        wb_valid, wb_reg_we;
    logic [4:0]  wb_rd_num;
    logic [31:0] wb_data;
    logic        ext_stall, flush;
    logic [31:0] alu__op1, alu__op2;
    logic [3:0]  alu__sel;
    logic [2:0]  brcond;
    logic        ex_valid, ex_reg_we, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd_num;
    logic [31:0] ex_store_data;
    logic        id_stall;

    int checks   = 0;
    int failures = 0;

    logic       shadowValid = 1'b0;
    logic [4:0] shadowRs    = '0;
    logic [4:0] shadowRt    = '0;

    mips_id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs_num     (id_rs_num),
        .id_rt_num     (id_rt_num),
        .id_rd_num     (id_rd_num),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_use_imm    (id_use_imm),
        .id_alu_sel    (id_alu_sel),
        .id_brcond     (id_brcond),
        .id_reg_we     (id_reg_we),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .mem_valid     (mem_valid),
        .mem_reg_we    (mem_reg_we),
        .mem_is_load   (mem_is_load),
        .mem_rd_num    (mem_rd_num),
        .mem_result    (mem_result),
        .wb_valid      (wb_valid),
        .wb_reg_we     (wb_reg_we),
        .wb_rd_num     (wb_rd_num),
        .wb_data       (wb_data),
        .ext_stall     (ext_stall),
        .flush         (flush),
        .alu__op1      (alu__op1),
        .alu__op2      (alu__op2),
        .alu__sel      (alu__sel),
        .brcond        (brcond),
        .ex_valid      (ex_valid),
        .ex_reg_we     (ex_reg_we),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_rd_num     (ex_rd_num),
        .ex_store_data (ex_store_data),
        .id_stall      (id_stall)
    );

    // 100 MHz core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A load in MEM must never match the register numbers of a valid EX
    // instruction; the stall logic is supposed to make that impossible.
    always @(negedge clk) begin
        if (!rst && ex_valid && shadowValid && mem_valid && mem_reg_we && mem_is_load &&
            mem_rd_num != 5'd0 && (mem_rd_num == shadowRs || mem_rd_num == shadowRt)) begin
            failures++;
            $error("FAIL memLoadMatch observed=rd%0d expected=no match", mem_rd_num);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearDownstream();
        mem_valid  = 1'b0; mem_reg_we = 1'b0; mem_is_load = 1'b0;
        mem_rd_num = '0;   mem_result = '0;
        wb_valid   = 1'b0; wb_reg_we  = 1'b0; wb_rd_num = '0; wb_data = '0;
    endtask

    task automatic applyStimulus(
        input logic valid, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic usesRs, input logic usesRt, input logic [31:0] rsData, input logic [31:0] rtData,
        input logic [31:0] imm, input logic useImm, input logic [3:0] sel, input logic [2:0] br,
        input logic we, input logic mr, input logic mw
    );
        id_valid   = valid;  id_rs_num  = rs;     id_rt_num  = rt;  id_rd_num = rd;
        id_uses_rs = usesRs; id_uses_rt = usesRt;
        id_rs_data = rsData; id_rt_data = rtData; id_imm     = imm; id_use_imm = useImm;
        id_alu_sel = sel;    id_brcond  = br;
        id_reg_we  = we;     id_mem_read = mr;    id_mem_write = mw;
    endtask

    // One clock: mirror what EX will hold, then sample 1 ns after the edge.
    task automatic tick();
        logic stallNow;
        #1;
        stallNow = id_stall;
        @(posedge clk);
        if (!rst && !ext_stall) begin
            if (flush || stallNow) begin
                shadowValid = 1'b0;
            end else begin
                shadowValid = id_valid;
                shadowRs    = id_rs_num;
                shadowRt    = id_rt_num;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; ext_stall = 1'b0; flush = 1'b0;
        clearDownstream();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 3'h0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("rstValid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rstSel",   {28'd0, alu__sel}, 32'd0);
        checkOutput("rstOp1",   alu__op1, 32'd0);
        checkOutput("rstStore", ex_store_data, 32'd0);
        rst = 1'b0;

        $display("[TB] add $3,$1,$2");
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd6, 32'd0, 0, 4'h2, 3'h1, 1, 0, 0);
        tick();
        checkOutput("addValid", {31'd0, ex_valid}, 32'd1);
        checkOutput("addOp1",   alu__op1, 32'd5);
        checkOutput("addOp2",   alu__op2, 32'd6);
        checkOutput("addSel",   {28'd0, alu__sel}, 32'h2);
        checkOutput("addBr",    {29'd0, brcond}, 32'h1);
        checkOutput("addRd",    {27'd0, ex_rd_num}, 32'd3);

        $display("[TB] reset mid-stream");
        rst = 1'b1; shadowValid = 1'b0;
        #1;
        checkOutput("midRstValid", {31'd0, ex_valid}, 32'd0);
        checkOutput("midRstSel",   {28'd0, alu__sel}, 32'd0);
        checkOutput("midRstOp1",   alu__op1, 32'd0);
        checkOutput("midRstWe",    {31'd0, ex_reg_we}, 32'd0);
        #1; rst = 1'b0;
        tick();
        checkOutput("postRstValid", {31'd0, ex_valid}, 32'd1);
        checkOutput("postRstOp1",   alu__op1, 32'd5);

        $display("[TB] sub $4,$3,$1 with MEM/WB forwarding");
        applyStimulus(1, 5'd3, 5'd1, 5'd4, 1, 1, 32'hDEAD, 32'd5, 32'd0, 0, 4'h3, 3'h0, 1, 0, 0);
        tick();
        mem_valid = 1; mem_reg_we = 1; mem_is_load = 0; mem_rd_num = 5'd3; mem_result = 32'h10;
        #1;
        checkOutput("fwdMemOp1", alu__op1, 32'h10);
        checkOutput("fwdMemOp2", alu__op2, 32'd5);
        wb_valid = 1; wb_reg_we = 1; wb_rd_num = 5'd3; wb_data = 32'h7;
        #1;
        checkOutput("fwdMemBeatsWb", alu__op1, 32'h10);
        mem_valid = 0;
        #1;
        checkOutput("fwdWbOp1", alu__op1, 32'h7);
        clearDownstream();

        $display("[TB] lw $5 then add $6,$5,$5");
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 0, 32'h100, 32'd0, 32'd4, 1, 4'h2, 3'h0, 1, 1, 0);
        tick();
        checkOutput("lwMemRead", {31'd0, ex_mem_read}, 32'd1);
        applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 1, 32'h1111, 32'h1111, 32'd0, 0, 4'h2, 3'h0, 1, 0, 0);
        #1;
        checkOutput("luStall", {31'd0, id_stall}, 32'd1);
        tick();
        checkOutput("luBubbleValid", {31'd0, ex_valid}, 32'd0);
        checkOutput("luBubbleWe",    {31'd0, ex_reg_we}, 32'd0);
        checkOutput("luBubbleRd",    {31'd0, ex_mem_read}, 32'd0);
        checkOutput("luStallOnce",   {31'd0, id_stall}, 32'd0);
        mem_valid = 1; mem_reg_we = 1; mem_is_load = 1; mem_rd_num = 5'd5; mem_result = 32'h9999;
        tick();
        clearDownstream();
        wb_valid = 1; wb_reg_we = 1; wb_rd_num = 5'd5; wb_data = 32'hABCD;
        #1;
        checkOutput("luAddValid", {31'd0, ex_valid}, 32'd1);
        checkOutput("luAddOp1",   alu__op1, 32'hABCD);
        checkOutput("luAddOp2",   alu__op2, 32'hABCD);
        checkOutput("luAddStore", ex_store_data, 32'hABCD);
        clearDownstream();

        $display("[TB] register 0");
        applyStimulus(1, 5'd1, 5'd0, 5'd0, 1, 0, 32'd0, 32'd0, 32'd0, 1, 4'h2, 3'h0, 1, 1, 0);
        tick();
        applyStimulus(1, 5'd0, 5'd0, 5'd7, 1, 1, 32'd0, 32'd0, 32'd0, 0, 4'h2, 3'h0, 1, 0, 0);
        #1;
        checkOutput("r0NoStall", {31'd0, id_stall}, 32'd0);
        tick();
        mem_valid = 1; mem_reg_we = 1; mem_is_load = 0; mem_rd_num = 5'd0; mem_result = 32'hFFFF;
        wb_valid  = 1; wb_reg_we  = 1; wb_rd_num = 5'd0; wb_data = 32'hEEEE;
        #1;
        checkOutput("r0Op1", alu__op1, 32'd0);
        checkOutput("r0Op2", alu__op2, 32'd0);
        clearDownstream();

        $display("[TB] flush during freeze");
        applyStimulus(1, 5'd1, 5'd0, 5'd8, 1, 0, 32'h55, 32'd0, 32'd0, 0, 4'h5, 3'h0, 1, 0, 0);
        tick();
        checkOutput("fsLoadRd", {27'd0, ex_rd_num}, 32'd8);
        applyStimulus(1, 5'd2, 5'd0, 5'd9, 1, 0, 32'h66, 32'd0, 32'd0, 0, 4'h6, 3'h0, 1, 0, 0);
        ext_stall = 1; flush = 1;
        wb_valid = 1; wb_reg_we = 1; wb_rd_num = 5'd1; wb_data = 32'h77;
        tick();
        wb_valid = 0;
        #1;
        checkOutput("fsHoldRd",    {27'd0, ex_rd_num}, 32'd8);
        checkOutput("fsHoldValid", {31'd0, ex_valid}, 32'd1);
        checkOutput("fsHoldSel",   {28'd0, alu__sel}, 32'h5);
        checkOutput("fsHoldWbRef", alu__op1, 32'h77);
        ext_stall = 0;
        tick();
        checkOutput("fsBubbleValid", {31'd0, ex_valid}, 32'd0);
        checkOutput("fsBubbleWe",    {31'd0, ex_reg_we}, 32'd0);
        flush = 0;
        clearDownstream();

        $display("[TB] sll $10,$2,4");
        applyStimulus(1, 5'd0, 5'd2, 5'd10, 0, 1, 32'd0, 32'h3, 32'h100, 1, 4'h8, 3'h0, 1, 0, 0);
        tick();
        mem_valid = 1; mem_reg_we = 1; mem_is_load = 0; mem_rd_num = 5'd2; mem_result = 32'h4242;
        #1;
        checkOutput("sllOp2",   alu__op2, 32'h100);
        checkOutput("sllStore", ex_store_data, 32'h4242);
        checkOutput("sllSel",   {28'd0, alu__sel}, 32'h8);
        clearDownstream();

        $display("[TB] capture-side WB merge");
        applyStimulus(1, 5'd11, 5'd0, 5'd12, 1, 0, 32'h1, 32'd0, 32'd0, 0, 4'h2, 3'h0, 1, 0, 0);
        wb_valid = 1; wb_reg_we = 1; wb_rd_num = 5'd11; wb_data = 32'h2222;
        tick();
        clearDownstream();
        #1;
        checkOutput("capWbOp1", alu__op1, 32'h2222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_id_ex_stage.md
Name: mips_id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined MIPS core; sits directly upstream of mips_ALU and drives its alu__op1, alu__op2, alu__sel and brcond inputs.
- Captures decoded operands and control from ID.
- Applies operand forwarding from the MEM and WB stages at the ALU input.
- Detects load-use hazards and inserts bubbles; honours pipeline freeze and branch flush.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-number width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs_num, id_rt_num, id_rd_num  in  REG_W  source and destination register numbers
- id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  extended immediate; shift amount lives in bits [10:6]
- id_use_imm  in  1  op2 takes the immediate
- id_alu_sel  in  4  ALU operation code
- id_brcond  in  3  branch condition code
- id_reg_we, id_mem_read, id_mem_write  in  1  control bits
- mem_valid, mem_reg_we, mem_is_load  in  1  state of the instruction in MEM
- mem_rd_num  in  REG_W;  mem_result  in  DATA_W
- wb_valid, wb_reg_we  in  1;  wb_rd_num  in  REG_W;  wb_data  in  DATA_W
- ext_stall  in  1  whole-pipeline freeze
- flush  in  1  branch taken; squash the ID instruction
- alu__op1, alu__op2  out  DATA_W  ALU operands
- alu__sel  out  4;  brcond  out  3
- ex_valid, ex_reg_we, ex_mem_read, ex_mem_write  out  1
- ex_rd_num  out  REG_W
- ex_store_data  out  DATA_W  forwarded rt value, for stores
- id_stall  out  1  ID must hold (load-use hazard)

Behaviour:
- Reset (async, rst=1): every registered field clears to 0, so ex_valid=0, all control bits 0, alu__sel=0 and brcond=0. With no forwarding hit, alu__op1=alu__op2=ex_store_data=0. Reset mid-operation discards the held instruction; the first edge after deassertion performs a normal capture.
- Hazard detect (combinational): id_stall = id_valid & ex_valid & ex_mem_read & (ex_rd_num!=0) & ((id_uses_rs & id_rs_num==ex_rd_num) | (id_uses_rt & id_rt_num==ex_rd_num)).
- Register update at each posedge clk, highest priority first:
  - HOLD (ext_stall=1): keep all fields. Stored rs/rt data are still refreshed from WB when a WB match occurs. A flush asserted during HOLD is deferred; its producer keeps flush high until ext_stall drops.
  - BUBBLE (flush=1 or id_stall=1): ex_valid, ex_reg_we, ex_mem_read and ex_mem_write all go to 0. Data fields are don't-care.
  - LOAD (otherwise): capture all id_* fields, with ex_valid=id_valid.
- Capture-side forwarding: the register file is not write-through. When storing rs (resp. rt) data, use wb_data if wb_valid & wb_reg_we & wb_rd_num!=0 & wb_rd_num==id_rs_num (resp. id_rt_num).
- Output forwarding (combinational, applies only when ex_valid=1), per operand, in priority order:
  1. MEM: mem_valid & mem_reg_we & !mem_is_load & mem_rd_num!=0 & match → mem_result.
  2. WB: wb_valid & wb_reg_we & wb_rd_num!=0 & match → wb_data.
  3. Otherwise the stored value.
- Operand mapping:
  - alu__op1 = forwarded rs.
  - alu__op2 = stored immediate when use_imm=1, never forwarded; otherwise forwarded rt.
  - ex_store_data = forwarded rt in all cases.
- Register 0: never forwarded, never causes a stall.
- A MEM-stage load that matches is impossible by construction, since id_stall has already inserted a bubble. Verification flags it as an assertion failure.
- Latency: one cycle from ID capture to ALU inputs. No internal FSM beyond the LOAD/BUBBLE/HOLD select.

Decomposition:
- The ALU_* and BR_* codes stay in the shared defines header. No new constants are required.
- Add an id_ex_t packed struct for the registered bundle to the shared package.
- One sub-module, mips_fwd_mux: a single-operand forwarding selector, instantiated twice for rs and rt.

Test Plan:
- Reset: rst=1 mid-stream → ex_valid=0, alu__sel=0, alu__op1=0 immediately; first LOAD after release captures correctly.
- Back-to-back ALU forwarding: `add $3,$1,$2`, then `sub $4,$3,$1`, with mem_result=0x10 on $3 → alu__op1=0x10. If WB also writes $3=0x7, MEM still wins and alu__op1 stays 0x10.
- Load-use: `lw $5`, then `add $6,$5,$5` → id_stall=1 for exactly one cycle and a bubble is inserted. Next cycle the add sees wb_data=0xABCD on both operands.
- Register 0: mem_rd_num=0, mem_reg_we=1, mem_result=0xFFFF, instruction reads $0 → alu__op1 = stored 0 and id_stall=0.
- Flush/stall priority: flush=1 with ext_stall=1 → register held. ext_stall drops with flush still 1 → bubble, ex_valid=0.
- Immediate/shift: `sll` with id_imm[10:6]=4 and use_imm=1, while MEM writes the rt register → alu__op2 = stored immediate (not forwarded), and ex_store_data = mem_result.
